// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opb,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] diff_s;

    // Single-step datapath; acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        rem_sh_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, opb};
        acc_next = {2*WIDTH{1'b0}};
        if (div_mode) begin
            // a clear borrow bit means the trial subtraction fits: keep it and set the quotient bit
            if (!diff_s[WIDTH]) begin
                acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; one bit per enabled cycle, sign fix-up at the end.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r, acc_step_s, acc_init_s, prod_s;
    logic [WIDTH-1:0]   opb_r, opb_init_s, a_abs_s, b_abs_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_hi_s, fix_lo_s;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               div_r, neg_q_r, neg_r_r, dz_r, busy_r, done_r;
    logic               is_md_s, signed_s, a_neg_s, b_neg_s;

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (div_r),
        .acc      (acc_r),
        .opb      (opb_r),
        .acc_next (acc_step_s)
    );

    // Operand decode: magnitudes and sign flags for the signed ops
    always_comb begin
        is_md_s    = ~op[2];
        signed_s   = (op == MDU_MULT) || (op == MDU_DIV);
        a_neg_s    = signed_s & rs_val[WIDTH-1];
        b_neg_s    = signed_s & rt_val[WIDTH-1];
        a_abs_s    = a_neg_s ? ({WIDTH{1'b0}} - rs_val) : rs_val;
        b_abs_s    = b_neg_s ? ({WIDTH{1'b0}} - rt_val) : rt_val;
        acc_init_s = {{WIDTH{1'b0}}, (op[1] ? a_abs_s : b_abs_s)};
        opb_init_s = op[1] ? b_abs_s : a_abs_s;
    end

    // Result fix-up; MIN/-1 overflow falls out of the magnitude path without a special case
    always_comb begin
        prod_s   = neg_q_r ? ({2*WIDTH{1'b0}} - acc_r) : acc_r;
        quo_s    = acc_r[WIDTH-1:0];
        rem_s    = acc_r[2*WIDTH-1:WIDTH];
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (div_r) begin
            fix_hi_s = neg_r_r ? ({WIDTH{1'b0}} - rem_s) : rem_s;
            if (dz_r) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_lo_s = neg_q_r ? ({WIDTH{1'b0}} - quo_s) : quo_s;
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && is_md_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else if (clk_enable) begin
            state_r <= state_nxt_s;
        end
    end

    // Working registers, counter and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {2*WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            div_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else if (clk_enable) begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && is_md_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        acc_r   <= acc_init_s;
                        opb_r   <= opb_init_s;
                        div_r   <= op[1];
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        dz_r    <= op[1] && (rt_val == {WIDTH{1'b0}});
                        busy_r  <= 1'b1;
                    end else if (start && (op == MDU_MTHI)) begin
                        hi_r <= rs_val;
                    end else if (start && (op == MDU_MTLO)) begin
                        lo_r <= rs_val;
                    end
                end
                RUN: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                FIX: begin
                    hi_r   <= fix_hi_s;
                    lo_r   <= fix_lo_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised iterative multiply/divide unit owning the HI/LO architectural registers. It replaces the combinational hilo path and serves the MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions. The CPU datapath issues an operation with a start pulse and stalls on busy. MFHI/MFLO read the hi/lo outputs directly.

Parameters:
WIDTH, 32, operand and HI/LO width; even, >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset (asserted when 0)
clk_enable  in  1  global clock enable; when 0, all state frozen
start  in  1  issue request, sampled on rising edge
op  in  3  operation code (mdu_op_t)
rs_val  in  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source)
rt_val  in  WIDTH  operand B (multiplier / divisor)
busy  out  1  unit occupied; CPU must stall any HI/LO access
done  out  1  one-cycle pulse: hi/lo just updated by MULT/DIV
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset==0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, working regs=0. Reset mid-operation aborts it; no partial result reaches hi/lo.
- clk_enable==0: no register changes at all, including done (it holds its value). Latency is stretched by each disabled cycle.
- Accept: start && clk_enable && state==IDLE at edge E0. start while busy is ignored (no queueing, no error).
- MTHI/MTLO: at E0, hi (or lo) <= rs_val. State stays IDLE. busy stays 0 and done stays 0.
- MULT/MULTU/DIV/DIVU at E0: operands captured, counter<=0, state<=RUN. Signed ops store absolute values plus result-sign flags.
- FSM states:
  - IDLE.
  - RUN: one radix-2 step per enabled edge. Multiply uses shift-add on a 2*WIDTH accumulator. Divide uses restoring shift-subtract. Counter increments; after WIDTH steps, go to FIX.
  - FIX: apply sign correction, write hi/lo, done<=1, then back to IDLE.
- busy = (state != IDLE). With clk_enable held high, busy is high for exactly WIDTH+1 cycles after E0.
- hi/lo update at edge E(WIDTH+1). done is high for the following cycle only, with busy already 0.
- Multiply results: {hi,lo} = full 2*WIDTH product, two's complement for MULT, unsigned for MULTU.
- Divide results: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (rt_val==0): lo = all ones, hi = rs_val (unsigned) or the signed dividend. Latency is unchanged.
- Signed overflow (DIV of most-negative value by -1): lo = most-negative value, hi = 0.
- Undefined op codes are treated as no-op: no state change.
- Operand inputs are don't-care after E0.

Decomposition:
- Package mdu_pkg holds:
  - typedef enum logic[2:0] mdu_op_t: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5.
  - typedef enum mdu_state_t: IDLE, RUN, FIX.
- One sub-module, mdu_step: combinational single-iteration datapath (add-or-shift / subtract-or-restore), selected by a mode bit. The top level holds the FSM, counter and HI/LO registers.

Test Plan:
1. WIDTH=32, MULT rs=0xFFFFFFFF rt=0x00000002 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
2. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=100 rt=7 -> lo=14, hi=2; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU rs=0x12345678 rt=0 -> lo=0xFFFFFFFF, hi=0x12345678, busy still 33 cycles.
4. MTHI rs=0xCAFEF00D -> hi updated next edge, busy never rises; MTLO issued 5 cycles into a MULT is ignored, and final lo equals the product low word.
5. Drive reset=0 at cycle 10 of a DIV -> hi=lo=0 and busy=0 immediately (asynchronous); after release, a new MULT 3*4 gives lo=12, hi=0.
6. Hold clk_enable=0 for 4 cycles mid-MULT -> busy lasts 37 cycles, result unchanged. Rerun with WIDTH=8: MULT 0x80*0x80 -> hi=0x40, lo=0x00 after 9 cycles.
